mem_byte_responder: RTL

MEM_BYTE_RESPONDER -- requirements
Module: mem_byte_responder

---
 rtl/mem_byte_responder_pkg.sv | 23 ++
 rtl/mem_byte_responder_byte_fifo.sv | 54 +++++
 rtl/mem_byte_responder.sv | 115 +++++++++++
 3 files changed

// File: rtl/mem_byte_responder_pkg.sv
// Shared address map and bus decode for the byte-wide memory/UART responder.
// The IO region occupies byte_a[17:16] == 2'b11; bits above 17 never take part in decode.
package mem_byte_responder_pkg;

    localparam logic [1:0]  IO_REGION    = 2'b11;
    localparam logic [17:0] IO_UART_DATA = 18'h30000;
    localparam logic [17:0] IO_STATUS    = 18'h30004;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_UART,
        SEL_STATUS,
        SEL_IO_NONE
    } bus_sel_e;

    function automatic bus_sel_e decode_sel(input logic [17:0] a);
        if (a[17:16] != IO_REGION) return SEL_RAM;
        if (a == IO_UART_DATA)     return SEL_UART;
        if (a == IO_STATUS)        return SEL_STATUS;
        return SEL_IO_NONE;
    endfunction

endpackage

// File: rtl/mem_byte_responder_byte_fifo.sv
// Byte FIFO with occupancy count; a push into a full FIFO is accepted only
// when a pop retires an entry on the same edge.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    store [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        head     = store[rd_ptr_q];
        count    = count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; emptiness is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (push_ok) store[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mem_byte_responder.sv
// Byte-addressed responder: synchronous RAM plus a UART data/status window
// backed by TX and RX byte FIFOs. Read data is registered (1-cycle latency).
module mem_byte_responder
    import mem_byte_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] byte_a,
    input  logic [7:0]  byte_din,
    input  logic        byte_wr,
    output logic [7:0]  byte_dout,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]            ram [0:(1 << ADDR_WIDTH) - 1];
    logic [ADDR_WIDTH-1:0] addr;
    bus_sel_e              sel;
    logic                  ram_we;
    logic                  unused_addr_hi;

    logic                  tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]            tx_head;
    logic [CW-1:0]         tx_count;
    logic                  rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]            rx_head;
    logic [CW-1:0]         rx_count;

    logic                  tx_overflow_q, tx_overflow_d;
    logic [7:0]            dout_q, dout_d;

    always_comb begin
        unused_addr_hi = ^byte_a;
        addr     = byte_a[ADDR_WIDTH-1:0];
        sel      = decode_sel(byte_a[17:0]);
        ram_we   = rdy_in && byte_wr && (sel == SEL_RAM);
        tx_push  = rdy_in && byte_wr && (sel == SEL_UART);
        rx_pop   = rdy_in && !byte_wr && (sel == SEL_UART) && !rx_empty;
        tx_pop   = !tx_empty && tx_ready;
        rx_push  = rx_valid && !rx_full;
    end

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (byte_din),
        .head  (tx_head),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_data),
        .head  (rx_head),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_comb begin
        // A drop is only an overflow if no drain frees a slot on the same edge.
        tx_overflow_d = tx_overflow_q | (tx_push && tx_full && !tx_pop);

        dout_d = dout_q;
        if (rdy_in && !byte_wr) begin
            unique case (sel)
                SEL_RAM:     dout_d = ram[addr];
                SEL_UART:    dout_d = rx_empty ? 8'h00 : rx_head;
                SEL_STATUS:  dout_d = {5'b0, tx_overflow_q, !rx_empty, tx_full};
                SEL_IO_NONE: dout_d = 8'h00;
                default:     dout_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dout_q        <= '0;
            tx_overflow_q <= 1'b0;
        end else begin
            dout_q        <= dout_d;
            tx_overflow_q <= tx_overflow_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (ram_we) ram[addr] <= byte_din;
    end

    always_comb begin
        byte_dout      = dout_q;
        tx_data        = tx_head;
        tx_valid       = !tx_empty;
        rx_ready       = !rx_full;
        io_buffer_full = (tx_count >= CW'(FIFO_DEPTH - 1));
    end

endmodule
